// File: rtl/cross_road_detector_pkg.sv
// Shared encodings for the cross-road request path: controller signal colours
// and the request FSM states.
package cross_road_detector_pkg;

    localparam logic [1:0] SIG_RED    = 2'b00;
    localparam logic [1:0] SIG_YELLOW = 2'b01;
    localparam logic [1:0] SIG_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } req_state_e;

    function automatic logic is_green(input logic [1:0] sig);
        return (sig == SIG_GREEN);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser and run-length debouncer for the raw loop sensor;
// emits the clean level and a one-cycle pulse on each debounced rising edge.
module sensor_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic clear_n,
    input  logic sensor_raw,
    output logic deb,
    output logic arrival
);

    localparam int DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEBOUNCE - 1);

    logic           sync1_q;
    logic           sens_s_q;
    logic           deb_q;
    logic           deb_d;
    logic           deb_prev_q;
    logic [DCW-1:0] dcnt_q;
    logic [DCW-1:0] dcnt_d;

    // The level only flips after DEBOUNCE consecutive disagreeing samples;
    // any agreeing sample restarts the run.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        if (sens_s_q != deb_q) begin
            if (dcnt_q == DCNT_LAST) begin
                deb_d = ~deb_q;
            end else begin
                dcnt_d = dcnt_q + DCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync1_q    <= 1'b0;
            sens_s_q   <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            dcnt_q     <= '0;
        end else begin
            sync1_q    <= sensor_raw;
            sens_s_q   <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
        end
    end

    assign deb     = deb_q;
    assign arrival = deb_q & ~deb_prev_q;

endmodule

// File: rtl/cross_road_detector.sv
// Cross-road vehicle detector: counts waiting vehicles from the debounced loop
// and green-light departures, and raises the request x with a minimum hold.
module cross_road_detector
    import cross_road_detector_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 4,
    parameter int MIN_HOLD = 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sensor_raw,
    input  logic             depart,
    input  logic [1:0]       cross_road,
    output logic             x,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             overflow
);

    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_INIT = HW'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             deb_level;
    logic             arrival;
    logic             arrival_ok;
    logic             dep_ok;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    req_state_e       state_q;
    req_state_e       state_d;
    logic [HW-1:0]    hold_q;
    logic [HW-1:0]    hold_d;
    logic             x_q;

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_sensor_debounce (
        .clk        (clk),
        .clear_n    (clear_n),
        .sensor_raw (sensor_raw),
        .deb        (deb_level),
        .arrival    (arrival)
    );

    // An arrival pulse is only ever meaningful while the clean level is high.
    assign arrival_ok = arrival & deb_level;
    assign dep_ok     = depart & is_green(cross_road);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        case ({arrival_ok, dep_ok})
            2'b10: begin
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // A new vehicle during HOLD re-enters REQ before the hold timer is considered.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    state_d = ST_REQ;
                end else if (hold_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= ST_IDLE;
            hold_q  <= '0;
            x_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            x_q     <= (state_d != ST_IDLE);
        end
    end

    assign x         = x_q;
    assign queue_cnt = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cross_road_detector.sv
// Scoreboard bench for cross_road_detector: directed scenarios plus random
// sensor/departure traffic checked against a windowed behavioural model.
module tb_cross_road_detector;

    localparam int DEBOUNCE = 4;
    localparam int CNT_W    = 4;
    localparam int MIN_HOLD = 2;
    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    logic             clk = 1'b0;
    logic             clear_n = 1'b0;
    logic             sensor_raw = 1'b0;
    logic             depart = 1'b0;
    logic [1:0]       cross_road = 2'b00;
    logic             x;
    logic [CNT_W-1:0] queue_cnt;
    logic             overflow;

    always #5 clk = ~clk;

    cross_road_detector #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W),
        .MIN_HOLD (MIN_HOLD)
    ) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .sensor_raw (sensor_raw),
        .depart     (depart),
        .cross_road (cross_road),
        .x          (x),
        .queue_cnt  (queue_cnt),
        .overflow   (overflow)
    );

    typedef struct {
        logic x;
        int   cnt;
        logic ovf;
        int   id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    // Reference model state: raw sample delay line, window of recent
    // synchronised samples, abstract counter and a history of counter values.
    bit m_s1, m_s2, m_deb, m_deb_d;
    bit sens_win[$];
    int cnt_hist[$];
    int m_cnt;
    bit m_ovf;

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_d = 0;
        sens_win.delete();
        cnt_hist.delete();
        m_cnt = 0;
        m_ovf = 0;
    endfunction

    // Advances the model across one clock edge and queues the outputs expected after it.
    function automatic void model_step(bit raw, bit dep, logic [1:0] cr);
        bit   arr;
        bit   dok;
        bit   nx;
        bit   flip;
        exp_t e;
        arr = m_deb && !m_deb_d;
        dok = dep && (cr == GREEN);
        // x is high iff the count was non-zero at any of the last MIN_HOLD+1 edges.
        cnt_hist.push_back(m_cnt);
        while (cnt_hist.size() > MIN_HOLD + 1) void'(cnt_hist.pop_front());
        nx = 0;
        foreach (cnt_hist[i]) if (cnt_hist[i] != 0) nx = 1;
        if (arr && !dok) begin
            if (m_cnt == (1 << CNT_W) - 1) m_ovf = 1;
            else m_cnt = m_cnt + 1;
        end else if (dok && !arr && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end
        // The level flips once the last DEBOUNCE samples all disagree with it.
        m_deb_d = m_deb;
        sens_win.push_back(m_s2);
        while (sens_win.size() > DEBOUNCE) void'(sens_win.pop_front());
        flip = (sens_win.size() == DEBOUNCE);
        foreach (sens_win[i]) if (sens_win[i] == m_deb) flip = 0;
        if (flip) m_deb = !m_deb;
        m_s2 = m_s1;
        m_s1 = raw;
        step_id++;
        e.x = nx; e.cnt = m_cnt; e.ovf = m_ovf; e.id = step_id;
        exp_q.push_back(e);
    endfunction

    task automatic cycle(input bit raw, input bit dep, input logic [1:0] cr);
        @(negedge clk);
        #1;
        sensor_raw = raw;
        depart     = dep;
        cross_road = cr;
        model_step(raw, dep, cr);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end else begin
            $display("check %s: %0d ok", name, got);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        clear_n    = 1'b1;
        sensor_raw = 1'b0;
        depart     = 1'b0;
        cross_road = RED;
        model_reset();
        model_step(1'b0, 1'b0, RED);
    endtask

    // Asserts clear_n between clock edges and checks outputs clear without an edge.
    task automatic async_reset_check(input string tag, input bit expect_x_high);
        @(negedge clk);
        #2;
        if (expect_x_high) check_val({tag, " x before reset"}, int'(x), 1);
        clear_n = 1'b0;
        #1;
        check_val({tag, " x in reset"}, int'(x), 0);
        check_val({tag, " queue_cnt in reset"}, int'(queue_cnt), 0);
        check_val({tag, " overflow in reset"}, int'(overflow), 0);
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (x !== mon_e.x || queue_cnt !== mon_e.cnt[CNT_W-1:0] || overflow !== mon_e.ovf) begin
                errors++;
                $display("FAIL step %0d outputs: got x=%b cnt=%0d ovf=%b expected x=%b cnt=%0d ovf=%b",
                         mon_e.id, x, queue_cnt, overflow, mon_e.x, mon_e.cnt, mon_e.ovf);
            end else begin
                $display("step %0d x=%b cnt=%0d ovf=%b ok", mon_e.id, x, queue_cnt, overflow);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int run;
        bit lvl;
        model_reset();
        repeat (3) @(negedge clk);
        release_reset();

        // Glitch shorter than DEBOUNCE is discarded.
        repeat (3) cycle(1'b1, 1'b0, RED);
        repeat (8) cycle(1'b0, 1'b0, RED);

        // Clean pulse, then a second vehicle.
        repeat (10) cycle(1'b1, 1'b0, RED);
        repeat (8) cycle(1'b0, 1'b0, RED);
        repeat (10) cycle(1'b1, 1'b0, RED);
        repeat (8) cycle(1'b0, 1'b0, RED);

        // Departure gating and release with hold.
        cycle(1'b0, 1'b1, RED);
        cycle(1'b0, 1'b1, YELLOW);
        cycle(1'b0, 1'b0, GREEN);
        cycle(1'b0, 1'b1, GREEN);
        cycle(1'b0, 1'b0, GREEN);
        cycle(1'b0, 1'b1, GREEN);
        repeat (6) cycle(1'b0, 1'b0, RED);

        // One vehicle queued, then arrival coinciding with a green departure.
        repeat (10) cycle(1'b1, 1'b0, RED);
        repeat (6) cycle(1'b0, 1'b0, RED);
        repeat (6) cycle(1'b1, 1'b0, RED);
        cycle(1'b1, 1'b1, GREEN);
        repeat (6) cycle(1'b0, 1'b0, RED);

        // Saturate the counter and overflow, then drain into HOLD and reset there.
        repeat (17) begin
            repeat (6) cycle(1'b1, 1'b0, RED);
            repeat (6) cycle(1'b0, 1'b0, RED);
        end
        repeat (4) cycle(1'b0, 1'b0, RED);
        while (m_cnt != 0) cycle(1'b0, 1'b1, GREEN);
        cycle(1'b0, 1'b0, RED);
        async_reset_check("mid-hold", 1'b1);

        // Random traffic with bouncy runs of random length.
        lvl = 0;
        for (int n = 0; n < 300; n++) begin
            lvl = !lvl;
            run = $urandom_range(1, 9);
            for (int c = 0; c < run; c++) begin
                cycle(lvl, ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 2)));
            end
            if (n == 150) async_reset_check("random", 1'b0);
        end
        repeat (12) cycle(1'b0, 1'b0, RED);

        @(negedge clk);
        @(negedge clk);
        check_val("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
